// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Program counter and fetch sequencer for the 9-bit processor.
//             It drives ProgCtr into the instruction ROM and steps the PC.
//             A taken beq redirects the PC through an internal branch-target
//             LUT. It also sequences program start, halt detection and the
//             Done handshake.
//  Ports    :
//    Clk        in   clock, rising-edge active
//    Reset      in   synchronous active-high reset (also clears the LUT)
//    Start      in   start request, honoured in IDLE and DONE only
//    Instr      in   [IW-1:0] instruction at ProgCtr (combinational ROM)
//    Branch     in   decoder branch flag for the current instruction
//    Zero       in   ALU equality result for the current beq
//    TgtWe      in   branch-target LUT write enable
//    TgtAddr    in   [LW-1:0] LUT write index
//    TgtData    in   [PW-1:0] LUT write data (absolute target)
//    ProgCtr    out  [PW-1:0] current program counter
//    Running    out  high while in RUN
//    Done       out  high while in DONE
//    CycleCount out  [15:0] executed-cycle counter, saturating
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
  parameter int unsigned     PW   = 10,
  parameter int unsigned     IW   = 9,
  parameter int unsigned     LW   = 4,
  parameter logic [IW-1:0]   HALT = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instr,
  input  logic          Branch,
  input  logic          Zero,
  input  logic          TgtWe,
  input  logic [LW-1:0] TgtAddr,
  input  logic [PW-1:0] TgtData,
  output logic [PW-1:0] ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [15:0]   CycleCount
);

  localparam int unsigned NTGT = 1 << LW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_pc;
  logic [15:0]   r_cnt;
  logic [PW-1:0] r_lut [NTGT];

  logic          w_halt;
  logic          w_taken;
  logic [PW-1:0] w_target;

  assign w_halt   = (Instr == HALT);
  assign w_taken  = Branch && Zero;
  // Read before the edge, so a same-edge LUT write is seen only next cycle.
  assign w_target = r_lut[Instr[LW-1:0]];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < NTGT; i++) begin
        r_lut[i] <= '0;
      end
    end else begin
      if (TgtWe) begin
        r_lut[TgtAddr] <= TgtData;
      end

      case (r_state)
        S_IDLE: begin
          r_pc <= '0;
          if (Start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          // The halt edge is an executed cycle too, so it is counted.
          if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
          if (w_halt) begin
            r_state <= S_DONE;
          end else if (w_taken) begin
            r_pc <= w_target;
          end else begin
            r_pc <= r_pc + PW'(1);
          end
        end
        S_DONE: begin
          if (Start) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_pc    <= '0;
        end
      endcase
    end
  end

  assign ProgCtr    = r_pc;
  assign CycleCount = r_cnt;
  assign Running    = (r_state == S_RUN);
  assign Done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed self-checking bench for instr_fetch. A behavioural
//             ROM and branch table answer combinationally from ProgCtr.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

  logic        Clk = 1'b0;
  logic        Reset, Start, Branch, Zero, TgtWe;
  logic [8:0]  Instr;
  logic [3:0]  TgtAddr;
  logic [9:0]  TgtData;
  logic [9:0]  ProgCtr;
  logic        Running, Done;
  logic [15:0] CycleCount;

  logic [8:0]  rom   [1024];
  logic        brtab [1024];

  int tests_run = 0;
  int tests_failed = 0;
  int exp_cnt = 0;

  always #5 Clk = ~Clk;

  assign Instr  = rom[ProgCtr];
  assign Branch = brtab[ProgCtr];

  instr_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr),
    .Branch(Branch), .Zero(Zero), .TgtWe(TgtWe), .TgtAddr(TgtAddr),
    .TgtData(TgtData), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .CycleCount(CycleCount)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One edge while the design is known to be in RUN.
  task automatic run_step();
    step();
    exp_cnt++;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      rom[a]   = 9'h1F0;
      brtab[a] = 1'b0;
    end
    rom[3] = 9'h000;
    Reset = 1'b1; Start = 1'b0; Zero = 1'b0;
    TgtWe = 1'b0; TgtAddr = '0; TgtData = '0;
    step();
    Reset = 1'b0;

    // Reset state, then idle with Start low.
    check("rst_pc", ProgCtr, 0);
    check("rst_run", Running, 0);
    check("rst_done", Done, 0);
    check("rst_cnt", CycleCount, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("idle_pc", ProgCtr, 0);
      check("idle_run", Running, 0);
      check("idle_done", Done, 0);
      check("idle_cnt", CycleCount, 0);
    end

    // Short program halting at address 3.
    Start = 1'b1;
    step();
    Start = 1'b0;
    exp_cnt = 0;
    check("start_run", Running, 1);
    check("start_pc", ProgCtr, 0);
    check("start_cnt", CycleCount, 0);
    for (int k = 1; k <= 3; k++) begin
      run_step();
      check("walk_pc", ProgCtr, k);
      check("walk_cnt", CycleCount, k);
    end
    step();
    check("halt_done", Done, 1);
    check("halt_run", Running, 0);
    check("halt_pc", ProgCtr, 3);
    check("halt_cnt", CycleCount, 4);
    step();
    check("frozen_pc", ProgCtr, 3);
    check("frozen_cnt", CycleCount, 4);
    check("frozen_done", Done, 1);

    // Restart from DONE.
    Start = 1'b1;
    step();
    Start = 1'b0;
    rom[3] = 9'h1F0;
    exp_cnt = 0;
    check("restart_pc", ProgCtr, 0);
    check("restart_done", Done, 0);
    check("restart_run", Running, 1);
    check("restart_cnt", CycleCount, 0);

    // LUT[5] = 40, then a taken branch at PC 7.
    TgtWe = 1'b1; TgtAddr = 4'd5; TgtData = 10'd40;
    run_step();
    TgtWe = 1'b0;
    check("lutw_pc", ProgCtr, 1);
    for (int k = 0; k < 6; k++) run_step();
    check("pre_br_pc", ProgCtr, 7);
    rom[7] = 9'h1F5; brtab[7] = 1'b1; Zero = 1'b1;
    run_step();
    check("br_taken_pc", ProgCtr, 40);
    brtab[7] = 1'b0;

    // Branch with Zero low falls through.
    rom[40] = 9'h1F5; brtab[40] = 1'b1; Zero = 1'b0;
    run_step();
    check("br_not_taken_pc", ProgCtr, 41);

    // Same-edge write and branch: old target used, new one next time.
    rom[41] = 9'h1F5; brtab[41] = 1'b1; Zero = 1'b1;
    TgtWe = 1'b1; TgtAddr = 4'd5; TgtData = 10'd60;
    run_step();
    TgtWe = 1'b0;
    check("same_edge_pc", ProgCtr, 40);
    run_step();
    check("new_target_pc", ProgCtr, 60);
    Zero = 1'b0; brtab[40] = 1'b0; brtab[41] = 1'b0;
    rom[7] = 9'h1F0; rom[40] = 9'h1F0; rom[41] = 9'h1F0;
    check("cnt_after_br", CycleCount, exp_cnt);

    // Straight line to the top of the address space and wrap.
    for (int k = 60; k < 1023; k++) run_step();
    check("top_pc", ProgCtr, 1023);
    run_step();
    check("wrap_pc", ProgCtr, 0);
    check("wrap_run", Running, 1);
    check("wrap_cnt", CycleCount, exp_cnt);

    // Start during RUN does nothing special.
    Start = 1'b1;
    run_step();
    Start = 1'b0;
    check("mid_start_pc", ProgCtr, 1);
    check("mid_start_cnt", CycleCount, exp_cnt);

    // Reset at PC 12 with concurrent Start and LUT write.
    for (int k = 1; k < 12; k++) run_step();
    check("pre_rst_pc", ProgCtr, 12);
    Reset = 1'b1; Start = 1'b1;
    TgtWe = 1'b1; TgtAddr = 4'd5; TgtData = 10'd99;
    step();
    Reset = 1'b0; Start = 1'b0; TgtWe = 1'b0;
    check("mid_rst_run", Running, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_pc", ProgCtr, 0);
    check("mid_rst_cnt", CycleCount, 0);

    // LUT was cleared: a taken branch through entry 5 lands on 0, not 1.
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("post_rst_start_run", Running, 1);
    rom[0] = 9'h1F5; brtab[0] = 1'b1; Zero = 1'b1;
    step();
    check("lut_cleared_pc", ProgCtr, 0);
    check("lut_cleared_cnt", CycleCount, 1);
    Zero = 1'b0; brtab[0] = 1'b0;
    step();
    check("post_clr_pc", ProgCtr, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
